// File: rtl/bcd_encode.sv
// bcd_encode: iterative packed-BCD to binary converter, most-significant digit first, one digit per cycle.
// Build option: define BCD_ENCODE_CLAMP_EN to clamp digits above 9 to 9 before the multiply-add.
module bcd_encode #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err
);
  // state | meaning
  // IDLE  | waiting for an input handshake
  // CONV  | folding one digit per cycle into the accumulator
  // DONE  | result presented until the consumer takes it
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         AW   = BIN_W + 4;
  localparam int         SW   = 4 * DIGITS;
  localparam logic [2:0] LAST = 3'(DIGITS - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d, acc_next;
  logic [SW-1:0]    sr_q, sr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             err_acc_q, err_acc_d;
  logic             err_q, err_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [3:0]       dig_raw, dig_eff;
  logic             dig_bad;
  logic             last_dig;
  logic             accept;
  logic             release_out;

  assign dig_raw     = sr_q[SW-1 -: 4];
  assign dig_bad     = (dig_raw > 4'd9);
  assign last_dig    = (cnt_q == LAST);
  assign accept      = in_valid & in_ready;
  assign release_out = out_valid & out_ready;

`ifdef BCD_ENCODE_CLAMP_EN
  assign dig_eff = dig_bad ? 4'd9 : dig_raw;
`else
  assign dig_eff = dig_raw;
`endif

  // acc*10 + d without a multiplier; wraps modulo 2^AW on invalid digits
  assign acc_next = (acc_q << 3) + (acc_q << 1) + AW'(dig_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CONV;
      CONV:    if (last_dig) state_d = DONE;
      DONE:    if (release_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    bin_out   = bin_q;
    err       = err_q;
  end

  always_comb begin
    acc_d     = acc_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    err_acc_d = err_acc_q;
    err_d     = err_q;
    bin_d     = bin_q;
    if (state_q == IDLE && accept) begin
      sr_d      = bcd_in;
      acc_d     = '0;
      cnt_d     = '0;
      err_acc_d = 1'b0;
    end else if (state_q == CONV) begin
      acc_d     = acc_next;
      sr_d      = sr_q << 4;
      cnt_d     = cnt_q + 3'd1;
      err_acc_d = err_acc_q | dig_bad;
      if (last_dig) begin
        bin_d = acc_next[BIN_W-1:0];
        err_d = err_acc_q | dig_bad;
      end
    end
  end

  // err is a separate output register so it stays stable until the next result
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      err_acc_q <= 1'b0;
      err_q     <= 1'b0;
      bin_q     <= '0;
    end else begin
      acc_q     <= acc_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      err_acc_q <= err_acc_d;
      err_q     <= err_d;
      bin_q     <= bin_d;
    end
  end

endmodule

// File: tb/tb_bcd_encode.sv
// tb_bcd_encode: randomized and directed checks of two bcd_encode instances (2-digit and 4-digit)
// against a positional-value model; honours BCD_ENCODE_CLAMP_EN.
module tb_bcd_encode;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  iv, ordy, ir, ov, er;
  logic [7:0]  bcd2;
  logic [15:0] bcd4;
  logic [6:0]  bin2;
  logic [13:0] bin4;

  int   total = 0;
  int   bad   = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_encode #(.DIGITS(2), .BIN_W(7)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .bcd_in(bcd2),
    .out_valid(ov[0]), .out_ready(ordy[0]), .bin_out(bin2), .err(er[0]));

  bcd_encode #(.DIGITS(4), .BIN_W(14)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .bcd_in(bcd4),
    .out_valid(ov[1]), .out_ready(ordy[1]), .bin_out(bin4), .err(er[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Value = sum of digit_k * 10^k, reduced to the output width.
  function automatic void ref_conv(input logic [15:0] v, input int nd, input int bw,
                                   output int val, output logic e);
    int p;
    int d;
    val = 0;
    e   = 1'b0;
    p   = 1;
    for (int k = 0; k < nd; k++) begin
      d = int'(v[4*k +: 4]);
      if (d > 9) e = 1'b1;
`ifdef BCD_ENCODE_CLAMP_EN
      if (d > 9) d = 9;
`endif
      val += d * p;
      p   *= 10;
    end
    val = val % (1 << bw);
  endfunction

  // Handshake model: 0 idle, 1 converting, 2 result held
  int   m_phase [2];
  int   m_left  [2];
  int   m_pend  [2];
  logic m_pend_e[2];
  int   m_bin   [2];
  logic m_err   [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_phase[i] = 0;
        m_bin[i]   = 0;
        m_err[i]   = 1'b0;
      end else begin
        case (m_phase[i])
          0: if (iv[i]) begin
            if (i == 0) ref_conv({8'h00, bcd2}, 2, 7, m_pend[i], m_pend_e[i]);
            else        ref_conv(bcd4, 4, 14, m_pend[i], m_pend_e[i]);
            m_left[i]  = (i == 0) ? 2 : 4;
            m_phase[i] = 1;
          end
          1: begin
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_phase[i] = 2;
              m_bin[i]   = m_pend[i];
              m_err[i]   = m_pend_e[i];
            end
          end
          default: if (ordy[i]) m_phase[i] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("in_ready%0d", i), 32'(ir[i]), 32'(m_phase[i] == 0));
        chk($sformatf("out_valid%0d", i), 32'(ov[i]), 32'(m_phase[i] == 2));
        if (i == 0) chk("bin_out0", 32'(bin2), m_bin[i]);
        else        chk("bin_out1", 32'(bin4), m_bin[i]);
        chk($sformatf("err%0d", i), 32'(er[i]), 32'(m_err[i]));
      end
    end
  end

  task automatic set_bcd(input int i, input logic [15:0] v);
    if (i == 0) bcd2 = v[7:0];
    else        bcd4 = v;
  endtask

  // exp < 0 leaves the result to the model compare only
  task automatic do_conv(input int i, input logic [15:0] v, input int hold,
                         input int exp, input logic exp_e, input string nm);
    int   n;
    logic [31:0] b;
    @(negedge clk);
    iv[i] = 1'b1;
    set_bcd(i, v);
    ordy[i] = (hold == 0);
    n = 0;
    while (!ir[i] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin chk({nm, "_accept_timeout"}, 1, 0); iv[i] = 1'b0; return; end
    @(negedge clk);
    iv[i] = 1'b0;
    set_bcd(i, 16'($urandom));
    n = 0;
    while (!ov[i] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin chk({nm, "_done_timeout"}, 1, 0); return; end
    b = (i == 0) ? 32'(bin2) : 32'(bin4);
    if (exp >= 0) begin
      chk(nm, b, exp);
      chk({nm, "_err"}, 32'(er[i]), 32'(exp_e));
    end
    for (int h = 0; h < hold; h++) begin
      iv[i] = 1'($urandom);
      set_bcd(i, 16'($urandom));
      @(negedge clk);
    end
    if (hold > 0) begin
      chk({nm, "_held"}, (i == 0) ? 32'(bin2) : 32'(bin4), b);
      chk({nm, "_held_valid"}, 32'(ov[i]), 1);
    end
    iv[i]   = 1'b0;
    ordy[i] = 1'b1;
    @(negedge clk);
    ordy[i] = 1'b0;
  endtask

  initial begin
    int   pv;
    logic pe;
    logic [15:0] r;
    rst = 1'b1; iv = '0; ordy = '0; bcd2 = '0; bcd4 = '0;
    for (int i = 0; i < 2; i++) begin m_phase[i] = 0; m_bin[i] = 0; m_err[i] = 1'b0; end
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_in_ready", 32'(ir[0]), 1);
    chk("reset_out_valid", 32'(ov[0]), 0);
    chk("reset_bin", 32'(bin2), 0);
    rst = 1'b0;

    ref_conv(16'h003A, 2, 7, pv, pe);
`ifdef BCD_ENCODE_CLAMP_EN
    chk("model_3A", pv, 39);
`else
    chk("model_3A", pv, 40);
`endif
    chk("model_3A_err", 32'(pe), 1);

    do_conv(0, 16'h0059, 0, 59, 1'b0, "conv_59");
    do_conv(0, 16'h0000, 0, 0, 1'b0, "conv_00");
    do_conv(0, 16'h0099, 0, 99, 1'b0, "conv_99");
    do_conv(0, 16'h0010, 0, 10, 1'b0, "conv_10");
`ifdef BCD_ENCODE_CLAMP_EN
    do_conv(0, 16'h003A, 0, 39, 1'b1, "conv_3A");
`else
    do_conv(0, 16'h003A, 0, 40, 1'b1, "conv_3A");
`endif
    for (int t = 0; t < 10; t++)
      for (int u = 0; u < 10; u++)
        do_conv(0, 16'((t << 4) | u), 0, t * 10 + u, 1'b0, "sweep");

    do_conv(0, 16'h0047, 5, 47, 1'b0, "backpressure_47");

    @(negedge clk);
    iv[0] = 1'b1; bcd2 = 8'h88;
    @(negedge clk);
    iv[0] = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(ir[0]), 1);
    chk("midrst_out_valid", 32'(ov[0]), 0);
    chk("midrst_bin", 32'(bin2), 0);
    chk("midrst_err", 32'(er[0]), 0);
    do_conv(0, 16'h0012, 0, 12, 1'b0, "after_rst_12");

    do_conv(1, 16'h2025, 0, 2025, 1'b0, "d4_2025");
    do_conv(1, 16'h9999, 2, 9999, 1'b0, "d4_9999");

    for (int k = 0; k < 40; k++) begin
      for (int d = 0; d < 4; d++) r[4*d +: 4] = 4'($urandom_range(0, 11));
      do_conv(k % 2, r, int'($urandom_range(0, 3)), -1, 1'b0, "random");
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
